// File: rtl/tron_pkg.sv
// Shared definitions for the Tron frame-buffer writer.
// Holds the display geometry, the colour and FSM state enums, the latched
// bike record and the pixel-to-word address helper.
package tron_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int WORDS = H_RES * V_RES / 2;

    // Colour codes stored in each 4-bit pixel; 0 is background.
    typedef enum logic [3:0] {
        BLACK  = 4'd0,
        BLUE   = 4'd1,
        ORANGE = 4'd2,
        CYAN   = 4'd3,
        YELLOW = 4'd4,
        RED    = 4'd5,
        GREEN  = 4'd6,
        WHITE  = 4'd7
    } colour_e;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_P1    = 2'd2,
        S_P2    = 2'd3
    } state_e;

    // One bike head as captured on a frame edge.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] color;
        logic       alive;
    } bike_t;

    // Word address for a 320-word line: y*320 built as (y<<8)+(y<<6),
    // plus the pixel pair index x/2 (passed in already halved).
    function automatic logic [18:0] word_addr(input logic [8:0] x_half,
                                              input logic [9:0] y);
        logic [18:0] y_w;
        y_w = {9'd0, y};
        return (y_w << 8) + (y_w << 6) + {10'd0, x_half};
    endfunction

endpackage

// File: rtl/frame_sync.sv
// Brings the asynchronous frame strobe into the Clk domain.
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   frame_clk_i  raw frame strobe (asynchronous)
//   frame_rise_o one-cycle pulse on each synchronised rising edge
module frame_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_clk_i,
    output logic frame_rise_o
);

    // [0],[1] form the two-flop synchroniser, [2] holds the previous level.
    logic [2:0] sync_q;

    // Shift the strobe through the synchroniser and history flop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk_i};
        end
    end

    assign frame_rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/trail_writer.sv
// Sole write master of the packed 4-bit colour frame buffer.
// Sweeps the buffer to background after reset or on request, and on each
// frame edge writes the two bike heads (bike 1 first, bike 2 second).
// Ports:
//   Clk, Reset          clock and synchronous active-low reset
//   frame_clk           asynchronous frame strobe
//   clear_req           one-cycle clear request
//   pN_x/pN_y/pN_color/pN_alive  bike head position, colour, write enable
//   WE/write_address/write_data/nib_we  registered frame RAM write port
//   busy                high whenever the FSM is not idle
//   clear_done          one-cycle pulse after the last sweep word
module trail_writer
    import tron_pkg::*;
#(
    parameter int H_RES = tron_pkg::H_RES,
    parameter int V_RES = tron_pkg::V_RES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        clear_req,
    input  logic [9:0]  p1_x,
    input  logic [9:0]  p1_y,
    input  logic [9:0]  p2_x,
    input  logic [9:0]  p2_y,
    input  logic [3:0]  p1_color,
    input  logic [3:0]  p2_color,
    input  logic        p1_alive,
    input  logic        p2_alive,
    output logic        WE,
    output logic [18:0] write_address,
    output logic [15:0] write_data,
    output logic [1:0]  nib_we,
    output logic        busy,
    output logic        clear_done
);

    localparam int          WORDS_L = H_RES * V_RES / 2;
    localparam logic [18:0] LAST_W  = 19'(WORDS_L - 1);
    localparam logic [9:0]  X_LIM   = 10'(H_RES);
    localparam logic [9:0]  Y_LIM   = 10'(V_RES);

    logic        frame_rise_s;
    state_e      state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic        clr_pend_q, clr_pend_d;
    logic        done_pend_q, done_pend_d;
    bike_t       b1_q, b1_d, b2_q, b2_d;
    bike_t       pix_s;
    logic        we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  nib_q, nib_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    frame_sync u_frame_sync (
        .clk_i        (Clk),
        .rst_ni       (Reset),
        .frame_clk_i  (frame_clk),
        .frame_rise_o (frame_rise_s)
    );

    // Pick the bike record serviced in the current cycle.
    always_comb begin
        pix_s = b1_q;
        if (state_q == S_P2) begin
            pix_s = b2_q;
        end else begin
            pix_s = b1_q;
        end
    end

    // Next-state, sweep counter, input latch and output-register inputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_pend_d  = clr_pend_q;
        done_pend_d = 1'b0;
        b1_d        = b1_q;
        b2_d        = b2_q;
        we_d        = 1'b0;
        addr_d      = 19'd0;
        data_d      = 16'h0000;
        nib_d       = 2'b00;
        busy_d      = (state_q != S_IDLE);
        // clear_done trails the last sweep write by one cycle.
        done_d      = done_pend_q;

        case (state_q)
            S_CLEAR: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                nib_d  = 2'b11;
                if (cnt_q == LAST_W) begin
                    state_d     = S_IDLE;
                    cnt_d       = 19'd0;
                    done_pend_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 19'd1;
                end
            end
            S_IDLE: begin
                if (clear_req || clr_pend_q) begin
                    state_d    = S_CLEAR;
                    cnt_d      = 19'd0;
                    clr_pend_d = 1'b0;
                end else if (frame_rise_s) begin
                    b1_d    = '{x: p1_x, y: p1_y, color: p1_color, alive: p1_alive};
                    b2_d    = '{x: p2_x, y: p2_y, color: p2_color, alive: p2_alive};
                    state_d = S_P1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_P1, S_P2: begin
                // Off-screen or dead bikes still consume their cycle.
                if (pix_s.alive && (pix_s.x < X_LIM) && (pix_s.y < Y_LIM)) begin
                    we_d   = 1'b1;
                    addr_d = word_addr(pix_s.x[9:1], pix_s.y);
                    data_d = {8'h00, pix_s.color, pix_s.color};
                    nib_d  = pix_s.x[0] ? 2'b01 : 2'b10;
                end else begin
                    we_d = 1'b0;
                end
                // A clear arriving mid-write waits for the return to idle.
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end else begin
                    clr_pend_d = clr_pend_q;
                end
                state_d = (state_q == S_P1) ? S_P2 : S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = 19'd0;
            end
        endcase
    end

    // State, latch and registered output stage.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= S_CLEAR;
            cnt_q       <= 19'd0;
            clr_pend_q  <= 1'b0;
            done_pend_q <= 1'b0;
            b1_q        <= '0;
            b2_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= 19'd0;
            data_q      <= 16'h0000;
            nib_q       <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_pend_q  <= clr_pend_d;
            done_pend_q <= done_pend_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            nib_q       <= nib_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign WE            = we_q;
    assign write_address = addr_q;
    assign write_data    = data_q;
    assign nib_we        = nib_q;
    assign busy          = busy_q;
    assign clear_done    = done_q;

endmodule

// File: doc/trail_writer.md
# trail_writer

Upstream writer for the 4-bit colour frame buffer that the display-side pixel combiner reads. On every game frame it latches both bike head positions and writes each bike's colour enum into the packed frame buffer. On reset or on request it sweeps the whole buffer to background (0). It is the only write master on the frame RAM.

## Interface
Parameters:
- H_RES, 640, horizontal pixels
- V_RES, 480, vertical pixels

Ports:
- Clk  in  1  system clock; the only clock
- Reset  in  1  synchronous, active-low reset
- frame_clk  in  1  ~60 Hz frame strobe from the VGA controller; asynchronous to Clk
- clear_req  in  1  one-cycle pulse that requests a full buffer clear
- p1_x, p2_x  in  10  bike head X, in pixels
- p1_y, p2_y  in  10  bike head Y, in pixels
- p1_color, p2_color  in  4  colour enum to write
- p1_alive, p2_alive  in  1  write is enabled only when high
- WE  out  1  frame RAM write strobe
- write_address  out  19  word address = y*(H_RES/2) + x/2
- write_data  out  16  {8'h00, c, c}
- nib_we  out  2  nibble lane enable; bit1 selects [7:4] (even x), bit0 selects [3:0] (odd x)
- busy  out  1  high in every state except S_IDLE
- clear_done  out  1  one-cycle pulse at the end of a sweep

## Operation
States:
- S_CLEAR: sweep
- S_IDLE: wait
- S_P1: write bike 1
- S_P2: write bike 2

Reset and clear:
- Reset low: all outputs 0, state forced to S_CLEAR, sweep counter 0.
- S_CLEAR writes one word per cycle, addresses 0 to WORDS-1 (WORDS = H_RES*V_RES/2 = 153600).
- Each sweep write drives write_data=0 and nib_we=2'b11.
- After the last word: clear_done pulses, state goes to S_IDLE.

Frame edge detection:
- frame_clk passes through a 2-FF synchroniser plus a rising-edge detector.

S_IDLE priority:
- A pending clear goes first: clear_req received now or latched earlier sends the block to S_CLEAR with the counter at 0.
- Otherwise a frame edge latches all p1/p2 inputs and goes to S_P1.

S_P1 / S_P2:
- Each state lasts exactly one cycle. S_P1 goes to S_P2, S_P2 goes to S_IDLE.
- WE is asserted only when alive=1 AND x<H_RES AND y<V_RES.
- Otherwise WE=0 and the cycle is still consumed.

Nibble lane:
- nib_we = 2'b10 for even x, 2'b01 for odd x.
- Colour is replicated in both nibbles of the low byte.

Events arriving while busy:
- clear_req in S_P1/S_P2 is latched as pending and taken on return to S_IDLE.
- clear_req in S_CLEAR is ignored; the sweep is not restarted.
- A frame edge outside S_IDLE is dropped, not queued.

Collisions and arithmetic:
- Both bikes on the same word, or same pixel: two writes, P2 last. P2 wins on a shared nibble.
- Address arithmetic is 19-bit unsigned: (y*320) + x[9:1]. y*320 is computed as (y<<8)+(y<<6).

## Timing
- All outputs are registered.
- Outputs appear one cycle after the state and counter values that produce them.
- Sweep length: 153600 cycles. clear_done rises in the cycle after the last write (address 153599).
- Frame latency: a frame_clk rise gives the bike-1 WE 4 Clk cycles later (2 sync, 1 edge, 1 output register). The bike-2 WE follows on the next cycle.
- Reset mid-operation (any state) aborts the current work and restarts the sweep. No partial write is emitted in the reset cycle.
- First sweep write: the first cycle after Reset returns high.

## Structure
- Package tron_pkg holds:
  - H_RES, V_RES, WORDS
  - colour enum typedef (BLACK=0, then the bike colours)
  - state typedef {S_CLEAR, S_IDLE, S_P1, S_P2}
- Sub-module frame_sync: 2-FF synchroniser plus rising-edge pulse for frame_clk.
- The FSM, sweep counter, input latch and address math stay in trail_writer.

## Test plan
- Release Reset -> WE high for exactly 153600 consecutive cycles, addresses 0..153599, write_data=0, nib_we=11, then one clear_done pulse and busy=0.
- Idle, p1=(101,10,4'h3,alive), p2=(200,479,4'h5,alive), frame_clk rise -> writes addr 3250 (data 0x0033, nib_we 01), then addr 153380 (data 0x0055, nib_we 10).
- p1_alive=0 and p2_x=640 -> two frames produce no WE, busy still pulses 2 cycles per frame.
- clear_req during S_P1 -> the S_P2 write completes, then the sweep starts the next cycle. clear_req during a sweep -> exactly one sweep.
- Both bikes at (50,50) with colours 3 and 7 -> two writes to addr 16025, the last with data 0x0077.
- Reset low for 1 cycle at sweep address 1000 -> the sweep restarts at 0. frame_clk toggled during the sweep -> no bike writes.
